// File: rtl/conv_pkg.sv
// Shared types and constants for the 4x4-by-3x3 convolution MAC engine.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int N_IN   = 16;
    localparam int N_F    = 9;
    localparam int N_OUT  = 4;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE,
        DONE
    } state_t;

    // Flat index into the 4x4 map for output position pos (2x2) and filter tap (3x3).
    function automatic logic [3:0] in_index(input logic [1:0] pos, input logic [3:0] tap);
        int row;
        int col;
        row = int'(pos[1]) + int'(tap) / 3;
        col = int'(pos[0]) + int'(tap) % 3;
        return 4'(row * 4 + col);
    endfunction

endpackage

// File: rtl/conv_mac_engine_mac_unit.sv
// Unsigned multiply-accumulate unit; clr takes priority over en.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              clr,
    input  logic              en,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// 4x4-by-3x3 valid-mode convolution, one MAC per cycle, 41-cycle latency.
// Optional CONV_SATURATE_EN clamps each stored result to 255.
module conv_mac_engine #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int ACC_W  = conv_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] input_data0,
    input  logic [DATA_W-1:0] input_data1,
    input  logic [DATA_W-1:0] input_data2,
    input  logic [DATA_W-1:0] input_data3,
    input  logic [DATA_W-1:0] input_data4,
    input  logic [DATA_W-1:0] input_data5,
    input  logic [DATA_W-1:0] input_data6,
    input  logic [DATA_W-1:0] input_data7,
    input  logic [DATA_W-1:0] input_data8,
    input  logic [DATA_W-1:0] input_data9,
    input  logic [DATA_W-1:0] input_data10,
    input  logic [DATA_W-1:0] input_data11,
    input  logic [DATA_W-1:0] input_data12,
    input  logic [DATA_W-1:0] input_data13,
    input  logic [DATA_W-1:0] input_data14,
    input  logic [DATA_W-1:0] input_data15,
    input  logic [DATA_W-1:0] filter_data0,
    input  logic [DATA_W-1:0] filter_data1,
    input  logic [DATA_W-1:0] filter_data2,
    input  logic [DATA_W-1:0] filter_data3,
    input  logic [DATA_W-1:0] filter_data4,
    input  logic [DATA_W-1:0] filter_data5,
    input  logic [DATA_W-1:0] filter_data6,
    input  logic [DATA_W-1:0] filter_data7,
    input  logic [DATA_W-1:0] filter_data8,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  conv_out0,
    output logic [ACC_W-1:0]  conv_out1,
    output logic [ACC_W-1:0]  conv_out2,
    output logic [ACC_W-1:0]  conv_out3
);

    import conv_pkg::*;

    logic [DATA_W-1:0] in_bus [N_IN];
    logic [DATA_W-1:0] f_bus  [N_F];
    logic [DATA_W-1:0] in_r   [N_IN];
    logic [DATA_W-1:0] f_r    [N_F];
    logic [ACC_W-1:0]  out_r  [N_OUT];

    state_t            state;
    state_t            state_next;
    logic [1:0]        pos;
    logic [3:0]        tap;
    logic              snap;
    logic              mac_clr;
    logic              mac_en;
    logic              store;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  store_val;

    assign in_bus = '{input_data0,  input_data1,  input_data2,  input_data3,
                      input_data4,  input_data5,  input_data6,  input_data7,
                      input_data8,  input_data9,  input_data10, input_data11,
                      input_data12, input_data13, input_data14, input_data15};
    assign f_bus  = '{filter_data0, filter_data1, filter_data2,
                      filter_data3, filter_data4, filter_data5,
                      filter_data6, filter_data7, filter_data8};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        snap       = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        store      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    snap       = 1'b1;
                    mac_clr    = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap == 4'd8) state_next = STORE;
            end
            STORE: begin
                store      = 1'b1;
                mac_clr    = 1'b1;
                state_next = (pos == 2'd3) ? DONE : MAC;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the operand snapshot is reset too, so the datapath never starts
    // from unknown contents after power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) in_r[i] <= '0;
            for (int i = 0; i < N_F; i++)  f_r[i]  <= '0;
        end else if (snap) begin
            in_r <= in_bus;
            f_r  <= f_bus;
        end
    end

    // tap holds at 8 on the last MAC so the filter index never leaves 0..8.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
            tap <= '0;
        end else if (snap) begin
            pos <= '0;
            tap <= '0;
        end else if (mac_en && tap != 4'd8) begin
            tap <= tap + 4'd1;
        end else if (store) begin
            tap <= '0;
            if (pos != 2'd3) pos <= pos + 2'd1;
        end
    end

    mac_unit #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .a  (in_r[in_index(pos, tap)]),
        .b  (f_r[tap]),
        .clr(mac_clr),
        .en (mac_en),
        .acc(acc)
    );

`ifdef CONV_SATURATE_EN
    assign store_val = (acc > ACC_W'(255)) ? ACC_W'(255) : acc;
`else
    assign store_val = acc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_OUT; i++) out_r[i] <= '0;
        end else if (store) begin
            out_r[pos] <= store_val;
        end
    end

    assign conv_out0 = out_r[0];
    assign conv_out1 = out_r[1];
    assign conv_out2 = out_r[2];
    assign conv_out3 = out_r[3];

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: stimulus pushes expected results from a
// direct-arithmetic convolution model; a negedge monitor pops on every done.
module tb_conv_mac_engine;

    localparam int DW = 8;
    localparam int AW = 20;

    localparam logic [7:0] PROD_IN [16] = '{15, 225, 61, 68, 169, 40, 71, 140,
                                            120, 9, 253, 246, 12, 151, 232, 234};
    localparam logic [7:0] PROD_F  [9]  = '{175, 196, 212, 117, 241, 69, 9, 255, 188};

`ifdef CONV_SATURATE_EN
    localparam int PROD_OUT0 = 255;
    localparam int FULL_OUT  = 255;
`else
    localparam int PROD_OUT0 = 144908;
    localparam int FULL_OUT  = 585225;
`endif

    typedef struct packed {
        logic [3:0][31:0] res;
        int               done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_v [16];
    logic [DW-1:0] f_v  [9];
    logic          busy;
    logic          done;
    logic [AW-1:0] conv_out [4];

    exp_t sb [$];
    exp_t e_mon;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv_mac_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .input_data0(in_v[0]),   .input_data1(in_v[1]),   .input_data2(in_v[2]),
        .input_data3(in_v[3]),   .input_data4(in_v[4]),   .input_data5(in_v[5]),
        .input_data6(in_v[6]),   .input_data7(in_v[7]),   .input_data8(in_v[8]),
        .input_data9(in_v[9]),   .input_data10(in_v[10]), .input_data11(in_v[11]),
        .input_data12(in_v[12]), .input_data13(in_v[13]), .input_data14(in_v[14]),
        .input_data15(in_v[15]),
        .filter_data0(f_v[0]), .filter_data1(f_v[1]), .filter_data2(f_v[2]),
        .filter_data3(f_v[3]), .filter_data4(f_v[4]), .filter_data5(f_v[5]),
        .filter_data6(f_v[6]), .filter_data7(f_v[7]), .filter_data8(f_v[8]),
        .busy(busy), .done(done),
        .conv_out0(conv_out[0]), .conv_out1(conv_out[1]),
        .conv_out2(conv_out[2]), .conv_out3(conv_out[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Valid-mode 2D convolution straight from its definition.
    function automatic exp_t model(input logic [7:0] a [16], input logic [7:0] f [9]);
        exp_t e;
        e.done_cyc = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                int unsigned sum = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        sum += int'(a[(r + i) * 4 + c + j]) * int'(f[i * 3 + j]);
`ifdef CONV_SATURATE_EN
                if (sum > 255) sum = 255;
`endif
                e.res[r * 2 + c] = sum;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done_queue_size", sb.size(), 1);
            end else begin
                e_mon = sb.pop_front();
                check("done_latency_cycle", cyc, e_mon.done_cyc);
                check("busy_during_done", busy, 1);
                for (int k = 0; k < 4; k++)
                    check($sformatf("conv_out%0d", k), conv_out[k], e_mon.res[k]);
            end
        end
    end

    task automatic set_ops(input logic [7:0] a [16], input logic [7:0] f [9]);
        in_v = a;
        f_v  = f;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 16; i++) in_v[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++)  f_v[i]  = 8'($urandom_range(0, 255));
    endtask

    // Pulse start for one cycle; returns just after the sampling edge.
    task automatic issue();
        exp_t e;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e = model(in_v, f_v);
        e.done_cyc = cyc + 40;
        sb.push_back(e);
        check("busy_after_start", busy, 1);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 200 && (sb.size() != 0 || busy); i++) @(negedge clk);
        check(name, (sb.size() != 0 || busy) ? 1 : 0, 0);
    endtask

    initial begin
        logic [7:0] id_f  [9];
        logic [7:0] ff_in [16];
        logic [7:0] ff_f  [9];
        exp_t       e;
        int         n0;
        int         d0;

        for (int i = 0; i < 9; i++)  id_f[i]  = (i == 4) ? 8'd1 : 8'd0;
        for (int i = 0; i < 16; i++) ff_in[i] = 8'd255;
        for (int i = 0; i < 9; i++)  ff_f[i]  = 8'd255;

        randomize_ops();
        start = 1'b1;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        for (int k = 0; k < 4; k++) check($sformatf("reset_conv_out%0d", k), conv_out[k], 0);
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b1;

        set_ops(PROD_IN, PROD_F);
        issue();
        drain("prod_drain");
        check("prod_conv_out0_const", conv_out[0], PROD_OUT0);

        set_ops(PROD_IN, id_f);
        issue();
        drain("ident_drain");
        check("ident_out0", conv_out[0], 40);
        check("ident_out1", conv_out[1], 71);
        check("ident_out2", conv_out[2], 9);
        check("ident_out3", conv_out[3], 253);

        set_ops(ff_in, ff_f);
        issue();
        drain("full_drain");
        for (int k = 0; k < 4; k++) check($sformatf("full_out%0d", k), conv_out[k], FULL_OUT);

        // Operands disturbed at cycle 5, start re-pulsed at cycle 10.
        randomize_ops();
        d0 = done_cnt;
        issue();
        repeat (4) @(posedge clk);
        #1 randomize_ops();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain("disturb_drain");
        check("disturb_done_count", done_cnt - d0, 1);

        // Reset at cycle 20 of a run aborts it with no done.
        randomize_ops();
        d0 = done_cnt;
        issue();
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int k = 0; k < 4; k++) check($sformatf("abort_conv_out%0d", k), conv_out[k], 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (45) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        set_ops(PROD_IN, PROD_F);
        issue();
        drain("post_abort_drain");
        check("post_abort_out0_const", conv_out[0], PROD_OUT0);

        // start held high: three accepted runs, 42 cycles apart.
        randomize_ops();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        e = model(in_v, f_v);
        for (int r = 0; r < 3; r++) begin
            e.done_cyc = n0 + 40 + 42 * r;
            sb.push_back(e);
        end
        repeat (84) @(posedge clk);
        #1 start = 1'b0;
        drain("held_drain");

        for (int r = 0; r < 5; r++) begin
            randomize_ops();
            issue();
            #20 randomize_ops();
            drain($sformatf("rand%0d_drain", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
